// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Program-counter unit for the instruction-fetch stage. It selects the next
//   fetch address from these sources, in priority order: reset, exception,
//   branch redirect, stall hold, predicted return, jump/call, and sequential.
//   The selected address is then registered into pc. Calls and returns are
//   predicted through a small circular return-address stack (RAS).
//
// Ports
//   clk        : single clock; all state changes on the rising edge
//   rst        : synchronous, active-high reset
//   stall      : hold pc; jump/call/ret are ignored while stalled
//   branch     : redirect from a later stage to pc_branch
//   pc_branch  : redirect target
//   jump       : unconditional jump to pc_jump
//   pc_jump    : jump target
//   call       : qualifies jump; pushes pc+INC onto the RAS
//   ret        : predicted return to the RAS top
//   exc        : exception; go to EXC_VECTOR and clear the RAS
//   pc         : registered fetch address
//   pc_next    : combinational next fetch address
//   ras_count  : number of valid RAS entries
//   ras_empty  : ras_count == 0
//   ras_full   : ras_count == RAS_DEPTH
//   ret_miss   : one-cycle pulse after a ret that was taken with an empty RAS
module pc_fetch_ctrl #(
  parameter int          W            = 32,
  parameter int unsigned INC          = 4,
  parameter logic [W-1:0] RESET_VECTOR = '0,
  parameter logic [W-1:0] EXC_VECTOR   = W'(32'h0000_0180),
  parameter int          RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         branch,
  input  logic [W-1:0]                 pc_branch,
  input  logic                         jump,
  input  logic [W-1:0]                 pc_jump,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         exc,
  output logic [W-1:0]                 pc,
  output logic [W-1:0]                 pc_next,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ret_miss
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [W-1:0]  INC_W  = W'(INC);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [W-1:0]  ras_mem [RAS_DEPTH];
  logic [PW-1:0] tp;
  logic [CW-1:0] count;

  logic [W-1:0]  pc_inc;
  logic          fetch_ok;
  logic          do_ret;
  logic          do_call;
  logic          replace_top;
  logic          push;
  logic          pop;
  logic [PW-1:0] wr_addr;

  assign pc_inc    = pc + INC_W;
  assign ras_empty = (count == '0);
  assign ras_full  = (count == DEPTH_C);
  assign ras_count = count;

  // Fetch-side control (jump/call/ret) only acts when nothing of higher
  // priority owns this cycle.
  assign fetch_ok = !rst && !exc && !branch && !stall;
  assign do_ret   = fetch_ok && ret;
  assign do_call  = fetch_ok && jump && call;

  // A ret and a call in the same cycle consume the top and push a new
  // return address, which collapses to overwriting the top in place. With an
  // empty stack there is nothing to consume, so it degrades to a plain push.
  assign replace_top = do_call && do_ret && !ras_empty;
  assign push        = do_call && !replace_top;
  assign pop         = do_ret && !do_call && !ras_empty;
  assign wr_addr     = replace_top ? tp : tp + PW'(1);

  always_comb begin
    pc_next = pc_inc;
    if (rst)
      pc_next = RESET_VECTOR;
    else if (exc)
      pc_next = EXC_VECTOR;
    else if (branch)
      pc_next = pc_branch;
    else if (stall)
      pc_next = pc;
    else if (ret)
      pc_next = ras_empty ? pc_inc : ras_mem[tp];
    else if (jump)
      pc_next = pc_jump;
  end

  // Stack contents need no reset; ras_count says which entries are valid.
  always_ff @(posedge clk) begin
    if (do_call)
      ras_mem[wr_addr] <= pc_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_VECTOR;
      tp       <= '0;
      count    <= '0;
      ret_miss <= 1'b0;
    end else begin
      pc       <= pc_next;
      ret_miss <= do_ret && ras_empty;
      if (exc) begin
        tp    <= '0;
        count <= '0;
      end else if (push) begin
        // When the stack is full, the oldest entry is silently overwritten.
        tp <= tp + PW'(1);
        if (!ras_full)
          count <= count + CW'(1);
      end else if (pop) begin
        tp    <= tp - PW'(1);
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV  = 32'h100;
  localparam logic [31:0] EV  = 32'h180;
  localparam int          DEP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, branch, jump, call, ret, exc;
  logic [31:0] pc_branch, pc_jump;
  logic [31:0] pc, pc_next;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ret_miss;

  pc_fetch_ctrl #(.W(32), .INC(4), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .RAS_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .pc_branch(pc_branch),
    .jump(jump), .pc_jump(pc_jump), .call(call), .ret(ret), .exc(exc),
    .pc(pc), .pc_next(pc_next), .ras_count(ras_count), .ras_empty(ras_empty),
    .ras_full(ras_full), .ret_miss(ret_miss)
  );

  // 8-bit instance used only for the address wrap check
  logic       rst8;
  logic [7:0] pc8, pc_next8;
  logic [2:0] ras_count8;
  logic       ras_empty8, ras_full8, ret_miss8;
  logic       zero = 1'b0;
  logic [7:0] zero8 = 8'h00;

  pc_fetch_ctrl #(.W(8), .INC(4), .RESET_VECTOR(8'hFC), .EXC_VECTOR(8'h80), .RAS_DEPTH(4)) dut8 (
    .clk(clk), .rst(rst8), .stall(zero), .branch(zero), .pc_branch(zero8),
    .jump(zero), .pc_jump(zero8), .call(zero), .ret(zero), .exc(zero),
    .pc(pc8), .pc_next(pc_next8), .ras_count(ras_count8), .ras_empty(ras_empty8),
    .ras_full(ras_full8), .ret_miss(ret_miss8)
  );

  typedef struct {
    logic        rst, stall, branch;
    logic [31:0] pcb;
    logic        jump;
    logic [31:0] pcj;
    logic        call, ret, exc;
    logic [31:0] epc;
    int          ecnt;
    logic        emiss;
  } vec_t;

  vec_t tv[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the return stack is a queue whose back is the top.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_miss;

  function automatic vec_t mk(logic r, logic s, logic b, logic [31:0] pb, logic j,
                              logic [31:0] pj, logic c, logic rt, logic e,
                              logic [31:0] epc, int ecnt, logic emiss);
    vec_t t;
    t.rst = r; t.stall = s; t.branch = b; t.pcb = pb; t.jump = j; t.pcj = pj;
    t.call = c; t.ret = rt; t.exc = e; t.epc = epc; t.ecnt = ecnt; t.emiss = emiss;
    return t;
  endfunction

  task automatic model_step(input vec_t t);
    logic [31:0] seq;
    seq    = m_pc + 32'd4;
    m_miss = 1'b0;
    if (t.rst) begin
      m_pc = RV;
      m_q.delete();
    end else if (t.exc) begin
      m_pc = EV;
      m_q.delete();
    end else if (t.branch) begin
      m_pc = t.pcb;
    end else if (t.stall) begin
      m_pc = m_pc;
    end else if (t.ret) begin
      if (m_q.size() > 0) m_pc = m_q[$];
      else begin
        m_pc   = seq;
        m_miss = 1'b1;
      end
      if (t.jump && t.call) begin
        if (m_q.size() > 0) m_q[$] = seq;
        else m_q.push_back(seq);
      end else if (m_q.size() > 0) begin
        void'(m_q.pop_back());
      end
    end else if (t.jump) begin
      m_pc = t.pcj;
      if (t.call) begin
        m_q.push_back(seq);
        if (m_q.size() > DEP) void'(m_q.pop_front());
      end
    end else begin
      m_pc = seq;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t t, input bit from_table);
    logic [31:0] epc;
    int          ecnt;
    logic        emiss;
    @(negedge clk);
    rst = t.rst; stall = t.stall; branch = t.branch; pc_branch = t.pcb;
    jump = t.jump; pc_jump = t.pcj; call = t.call; ret = t.ret; exc = t.exc;
    model_step(t);
    if (from_table) begin
      epc = t.epc; ecnt = t.ecnt; emiss = t.emiss;
    end else begin
      epc = m_pc; ecnt = m_q.size(); emiss = m_miss;
    end
    #1;
    n_vec++;
    chk("pc_next", pc_next, epc);
    @(posedge clk);
    #1;
    chk("pc", pc, epc);
    chk("ras_count", 32'(ras_count), 32'(ecnt));
    chk("ras_empty", 32'(ras_empty), 32'(ecnt == 0));
    chk("ras_full", 32'(ras_full), 32'(ecnt == DEP));
    chk("ret_miss", 32'(ret_miss), 32'(emiss));
  endtask

  initial begin
    vec_t t;
    rst = 1'b1; stall = 0; branch = 0; jump = 0; call = 0; ret = 0; exc = 0;
    pc_branch = '0; pc_jump = '0; rst8 = 1'b1;
    m_pc = RV; m_miss = 0;

    //        rst stl br pcb      jmp pcj       cal ret exc  exp_pc   cnt miss
    tv.push_back(mk(1, 0, 0, 0,       0, 0,        0, 0, 0, 32'h100, 0, 0));
    tv.push_back(mk(1, 0, 0, 0,       0, 0,        0, 0, 0, 32'h100, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 0, 0, 32'h104, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 0, 0, 32'h108, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 0, 0, 32'h10C, 0, 0));
    tv.push_back(mk(0, 0, 1, 32'h20,  0, 0,        0, 0, 0, 32'h20,  0, 0));
    tv.push_back(mk(0, 1, 0, 0,       0, 0,        0, 0, 0, 32'h20,  0, 0));
    tv.push_back(mk(0, 1, 0, 0,       0, 0,        0, 0, 0, 32'h20,  0, 0));
    tv.push_back(mk(0, 1, 0, 0,       0, 0,        0, 0, 0, 32'h20,  0, 0));
    tv.push_back(mk(0, 1, 1, 32'h400, 0, 0,        0, 0, 0, 32'h400, 0, 0));
    tv.push_back(mk(0, 1, 0, 0,       1, 32'h900,  1, 1, 0, 32'h400, 0, 0));
    // call/ret pair
    tv.push_back(mk(0, 0, 1, 32'h40,  0, 0,        0, 0, 0, 32'h40,  0, 0));
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h800,  1, 0, 0, 32'h800, 1, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 0, 0, 32'h804, 1, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 0, 0, 32'h808, 1, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 1, 0, 32'h44,  0, 0));
    // nested 3-deep
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h1000, 1, 0, 0, 32'h1000, 1, 0));
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h2000, 1, 0, 0, 32'h2000, 2, 0));
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h3000, 1, 0, 0, 32'h3000, 3, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 1, 0, 32'h2004, 2, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 1, 0, 32'h1004, 1, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 1, 0, 32'h48,   0, 0));
    // overflow then underflow
    tv.push_back(mk(0, 0, 1, 32'h10,  0, 0,        0, 0, 0, 32'h10, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h20,   1, 0, 0, 32'h20, 1, 0));
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h30,   1, 0, 0, 32'h30, 2, 0));
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h40,   1, 0, 0, 32'h40, 3, 0));
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h50,   1, 0, 0, 32'h50, 4, 0));
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h60,   1, 0, 0, 32'h60, 4, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 1, 0, 32'h54, 3, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 1, 0, 32'h44, 2, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 1, 0, 32'h34, 1, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 1, 0, 32'h24, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 1, 0, 32'h28, 0, 1));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 0, 0, 32'h2C, 0, 0));
    // same-cycle ret + call, non-empty then empty
    tv.push_back(mk(0, 0, 1, 32'h80,  0, 0,        0, 0, 0, 32'h80, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h90,   1, 0, 0, 32'h90, 1, 0));
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h999,  1, 1, 0, 32'h84, 1, 0));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 1, 0, 32'h94, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h500,  1, 1, 0, 32'h98, 1, 1));
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        0, 1, 0, 32'h98, 0, 0));
    // exception priority
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h200,  1, 0, 0, 32'h200, 1, 0));
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h300,  1, 0, 0, 32'h300, 2, 0));
    tv.push_back(mk(0, 1, 1, 32'h700, 0, 0,        0, 1, 1, 32'h180, 0, 0));
    tv.push_back(mk(1, 0, 0, 0,       0, 0,        0, 0, 1, 32'h100, 0, 0));
    // call without jump, plain jump
    tv.push_back(mk(0, 0, 0, 0,       0, 0,        1, 0, 0, 32'h104, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,       1, 32'h600,  0, 0, 0, 32'h600, 0, 0));

    foreach (tv[i]) step(tv[i], 1'b1);

    // W=8 wrap: reset lands on 0xFC, next sequential address wraps to 0x00
    @(negedge clk); rst8 = 1'b1;
    @(posedge clk); #1;
    n_vec++; chk("w8_reset_pc", 32'(pc8), 32'h0FC);
    @(negedge clk); rst8 = 1'b0;
    #1; n_vec++; chk("w8_pc_next_wrap", 32'(pc_next8), 32'h000);
    @(posedge clk); #1;
    n_vec++; chk("w8_pc_wrap", 32'(pc8), 32'h000);
    @(posedge clk); #1;
    n_vec++; chk("w8_pc_after_wrap", 32'(pc8), 32'h004);

    // randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      t.rst    = ($urandom_range(0, 59) == 0);
      t.exc    = ($urandom_range(0, 29) == 0);
      t.branch = ($urandom_range(0, 9) == 0);
      t.stall  = ($urandom_range(0, 5) == 0);
      t.ret    = ($urandom_range(0, 3) == 0);
      t.jump   = ($urandom_range(0, 2) == 0);
      t.call   = ($urandom_range(0, 1) == 0);
      t.pcb    = $urandom() & 32'hFFFF_FFFC;
      t.pcj    = (i % 50 == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      t.epc = '0; t.ecnt = 0; t.emiss = 1'b0;
      step(t, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
